// File: rtl/status_pkg.sv
// Shared types for the status register bank: write modes, response FSM states
// and the per-bit write-mode merge used by every register entry.
package status_pkg;

  typedef enum logic [1:0] {
    WM_OVERWRITE = 2'd0,
    WM_SET       = 2'd1,
    WM_CLEAR     = 2'd2,
    WM_RSVD      = 2'd3
  } wmode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } rsp_state_e;

  // Merge is purely bitwise, so it is defined on one bit and looped by callers.
  function automatic logic wmode_merge_bit(input logic cur, input wmode_e mode, input logic wd);
    logic nxt;
    nxt = cur;
    case (mode)
      WM_OVERWRITE: nxt = wd;
      WM_SET:       nxt = cur | wd;
      WM_CLEAR:     nxt = cur & ~wd;
      default:      nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/status_bank_entry.sv
// One status register plus its changed-since-read flag; updates one cycle after
// the write/read strobes, no backpressure (strobes are always absorbed).
module status_bank_entry
  import status_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  wmode_e            wmode,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_clr,
  input  logic              cor,
  output logic [DATA_W-1:0] val,
  output logic              chg
);

  logic [DATA_W-1:0] val_q, val_d;
  logic [DATA_W-1:0] base;
  logic              chg_q, chg_d;

  // A clear-on-read takes effect before a same-cycle write; only a change made
  // by the write itself re-arms the flag, so a read never re-flags its own clear.
  always_comb begin
    base = (rd_clr && cor) ? '0 : val_q;
    val_d = base;
    if (wr_en) begin
      for (int b = 0; b < DATA_W; b++) begin
        val_d[b] = wmode_merge_bit(base[b], wmode, wdata[b]);
      end
    end
    chg_d = chg_q;
    if (rd_clr) chg_d = 1'b0;
    if (val_d != base) chg_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      chg_q <= 1'b0;
    end else begin
      val_q <= val_d;
      chg_q <= chg_d;
    end
  end

  assign val = val_q;
  assign chg = chg_q;

endmodule

// File: rtl/status_bank.sv
// Bank of core-written status registers with a valid/ready read port (response one
// cycle after accept, one outstanding, held while rsp_ready low) and change IRQ.
module status_bank
  import status_pkg::*;
#(
  parameter int                  NUM_REGS = 4,
  parameter int                  DATA_W   = 16,
  parameter logic [NUM_REGS-1:0] COR_MASK = '0,
  localparam int                 ADDR_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_wen,
  input  logic [ADDR_W-1:0]   core_waddr,
  input  logic [1:0]          core_wmode,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic                stat_req_valid,
  output logic                stat_req_ready,
  input  logic [ADDR_W-1:0]   stat_req_addr,
  output logic                stat_rsp_valid,
  input  logic                stat_rsp_ready,
  output logic [DATA_W-1:0]   stat_rsp_data,
  output logic                stat_rsp_err,
  input  logic [NUM_REGS-1:0] irq_en,
  output logic                stat_irq,
  output logic [NUM_REGS-1:0] chg_pending
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  rsp_state_e        state_q, state_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              irq_q, irq_d;

  logic              wr_ok, rd_ok, req_acc;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] reg_val [NUM_REGS];

  assign wr_ok          = core_wen && ({1'b0, core_waddr} < NUM_REGS_W);
  assign rd_ok          = {1'b0, stat_req_addr} < NUM_REGS_W;
  assign stat_rsp_valid = (state_q == ST_RESP);
  assign stat_req_ready = !stat_rsp_valid || stat_rsp_ready;
  assign req_acc        = stat_req_valid && stat_req_ready;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
    status_bank_entry #(
      .DATA_W(DATA_W)
    ) u_entry (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_ok && (core_waddr == ADDR_W'(gi))),
      .wmode (wmode_e'(core_wmode)),
      .wdata (core_wdata),
      .rd_clr(req_acc && rd_ok && (stat_req_addr == ADDR_W'(gi))),
      .cor   (COR_MASK[gi]),
      .val   (reg_val[gi]),
      .chg   (chg_pending[gi])
    );
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_ok && (stat_req_addr == ADDR_W'(i))) rd_data = reg_val[i];
    end
  end

  // An accept in RESP can only happen while the current response is consumed.
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: if (req_acc) state_d = ST_RESP;
      ST_RESP: if (req_acc) state_d = ST_RESP;
               else if (stat_rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (req_acc) begin
      rsp_data_d = rd_data;
      rsp_err_d  = !rd_ok;
    end
    irq_d = |(chg_pending & irq_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      irq_q      <= irq_d;
    end
  end

  assign stat_rsp_data = rsp_data_q;
  assign stat_rsp_err  = rsp_err_q;
  assign stat_irq      = irq_q;

endmodule

// File: tb/tb_status_bank.sv
// Directed bench for status_bank: stimulus pushes expected responses, a monitor
// pops and checks them. Five registers so that address 5 is out of range.
module tb_status_bank;

  localparam int NR = 5;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam logic [1:0] OVW = 2'd0, SET = 2'd1, CLR = 2'd2, RSV = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_wen;
  logic [AW-1:0] core_waddr;
  logic [1:0]    core_wmode;
  logic [DW-1:0] core_wdata;
  logic          stat_req_valid;
  logic          stat_req_ready;
  logic [AW-1:0] stat_req_addr;
  logic          stat_rsp_valid;
  logic          stat_rsp_ready;
  logic [DW-1:0] stat_rsp_data;
  logic          stat_rsp_err;
  logic [NR-1:0] irq_en;
  logic          stat_irq;
  logic [NR-1:0] chg_pending;

  status_bank #(
    .NUM_REGS(NR),
    .DATA_W  (DW),
    .COR_MASK(5'b00100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .core_wen      (core_wen),
    .core_waddr    (core_waddr),
    .core_wmode    (core_wmode),
    .core_wdata    (core_wdata),
    .stat_req_valid(stat_req_valid),
    .stat_req_ready(stat_req_ready),
    .stat_req_addr (stat_req_addr),
    .stat_rsp_valid(stat_rsp_valid),
    .stat_rsp_ready(stat_rsp_ready),
    .stat_rsp_data (stat_rsp_data),
    .stat_rsp_err  (stat_rsp_err),
    .irq_en        (irq_en),
    .stat_irq      (stat_irq),
    .chg_pending   (chg_pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   presented = 1'b0;
  int   last_wait = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: checks every presented response against the queue head.
  always @(negedge clk) begin
    if (!rst && stat_rsp_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h with no request pending", stat_rsp_data);
      end else begin
        if (!presented) begin
          chk("rsp_latency", cyc, q[0].acc + 1);
          presented = 1'b1;
        end
        chk("rsp_data", {16'h0, stat_rsp_data}, {16'h0, q[0].data});
        chk("rsp_err", {31'h0, stat_rsp_err}, {31'h0, q[0].err});
        if (stat_rsp_ready) begin
          void'(q.pop_front());
          presented = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [1:0] m, input logic [DW-1:0] d);
    core_wen = 1'b1; core_waddr = a; core_wmode = m; core_wdata = d;
    step();
    core_wen = 1'b0;
  endtask

  // Leaves stat_req_valid high so consecutive calls issue one request per cycle.
  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    exp_t x;
    int   w;
    stat_req_valid = 1'b1;
    stat_req_addr  = a;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!stat_req_ready && w < 20);
    if (!stat_req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: stat_req_ready low for %0d cycles, expected high", w);
    end else begin
      x.data = d; x.err = e; x.acc = cyc;
      q.push_back(x);
    end
    last_wait = w;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; core_wen = 1'b0; core_waddr = '0; core_wmode = OVW; core_wdata = '0;
    stat_req_valid = 1'b0; stat_req_addr = '0; stat_rsp_ready = 1'b1; irq_en = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", stat_rsp_valid, 0);
    chk("reset_rsp_data", stat_rsp_data, 0);
    chk("reset_rsp_err", stat_rsp_err, 0);
    chk("reset_irq", stat_irq, 0);
    chk("reset_chg", chg_pending, 0);
    chk("reset_req_ready", stat_req_ready, 1);
    step();

    for (int i = 0; i < NR; i++) issue(AW'(i), 16'h0000, 1'b0);
    stat_req_valid = 1'b0;
    @(negedge clk); chk("irq_after_reads", stat_irq, 0); step();

    // Write modes on reg1: 0x00F0 | 0x0F00 & ~0x0030 = 0x0FC0
    wr(1, OVW, 16'h00F0);
    @(negedge clk); chk("chg1_after_write", chg_pending[1], 1); step();
    wr(1, SET, 16'h0F00);
    wr(1, CLR, 16'h0030);
    @(negedge clk); chk("chg1_before_read", chg_pending[1], 1); step();
    issue(1, 16'h0FC0, 1'b0);
    stat_req_valid = 1'b0;
    @(negedge clk); chk("chg1_after_read", chg_pending[1], 0); step();

    // Clear-on-read on reg2
    wr(2, OVW, 16'hBEEF);
    issue(2, 16'hBEEF, 1'b0);
    stat_req_valid = 1'b0;
    step();
    issue(2, 16'h0000, 1'b0);
    stat_req_valid = 1'b0;
    @(negedge clk); chk("chg2_after_cor", chg_pending[2], 0); step();

    // Same-cycle write and read of reg2
    wr(2, OVW, 16'hBEEF);
    core_wen = 1'b1; core_waddr = 2; core_wmode = OVW; core_wdata = 16'h1234;
    issue(2, 16'hBEEF, 1'b0);
    core_wen = 1'b0;
    stat_req_valid = 1'b0;
    @(negedge clk); chk("chg2_same_cycle", chg_pending[2], 1); step();
    issue(2, 16'h1234, 1'b0);
    stat_req_valid = 1'b0;
    step();

    // Writes that must not flag a change
    wr(1, OVW, 16'h0FC0);
    @(negedge clk); chk("chg1_same_value", chg_pending[1], 0); step();
    wr(4, RSV, 16'hFFFF);
    @(negedge clk); chk("chg4_reserved_mode", chg_pending[4], 0); step();
    wr(5, OVW, 16'hFFFF);
    @(negedge clk); chk("chg_out_of_range_write", chg_pending, 0); step();

    // Backpressure, then back-to-back reads including out-of-range addresses
    stat_rsp_ready = 1'b0;
    issue(1, 16'h0FC0, 1'b0);
    stat_req_addr = 3;
    repeat (5) begin
      @(negedge clk); chk("req_ready_held", stat_req_ready, 0);
    end
    step();
    stat_rsp_ready = 1'b1;
    issue(3, 16'h0000, 1'b0); chk("b2b_wait_r3", last_wait, 1);
    issue(4, 16'h0000, 1'b0); chk("b2b_wait_r4", last_wait, 1);
    issue(5, 16'h0000, 1'b1); chk("b2b_wait_r5", last_wait, 1);
    issue(7, 16'h0000, 1'b1); chk("b2b_wait_r7", last_wait, 1);
    stat_req_valid = 1'b0;
    step();

    // Interrupt: only reg0 watched
    irq_en = 5'b00001;
    wr(3, OVW, 16'h0001);
    @(negedge clk); chk("chg3_set", chg_pending[3], 1); chk("irq_unwatched_a", stat_irq, 0); step();
    @(negedge clk); chk("irq_unwatched_b", stat_irq, 0); step();
    wr(0, OVW, 16'h00AA);
    @(negedge clk); chk("chg0_set", chg_pending[0], 1); chk("irq_lag", stat_irq, 0); step();
    @(negedge clk); chk("irq_asserted", stat_irq, 1); step();
    issue(0, 16'h00AA, 1'b0);
    stat_req_valid = 1'b0;
    @(negedge clk); chk("chg0_cleared", chg_pending[0], 0); chk("irq_still_high", stat_irq, 1); step();
    @(negedge clk); chk("irq_dropped", stat_irq, 0); step();

    // Reset while a response is held
    stat_rsp_ready = 1'b0;
    issue(1, 16'h0FC0, 1'b0);
    stat_req_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    presented = 1'b0;
    step();
    step();
    rst = 1'b0;
    stat_rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", stat_rsp_valid, 0);
    chk("midrst_req_ready", stat_req_ready, 1);
    chk("midrst_chg", chg_pending, 0);
    chk("midrst_irq", stat_irq, 0);
    step();
    issue(1, 16'h0000, 1'b0);
    stat_req_valid = 1'b0;
    step();
    step();
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
